// File: rtl/block_sync_pkg.sv
// -----------------------------------------------------------------------------
// block_sync_pkg
// Shared types and constants for the block register bulk-sync producer.
//   sync_state_t   : producer FSM states
//   SYNC_DWELL_MIN : shortest legal hold time of one address on the sync bus
//   addr_width()   : index width for a table of n entries (never below 1 bit)
// -----------------------------------------------------------------------------
package block_sync_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    WALK  = 2'd2,
    DRAIN = 2'd3
  } sync_state_t;

  // The register file sees an address change one cycle late and then writes
  // the held address, so every address must stay on the bus at least 2 cycles.
  localparam int SYNC_DWELL_MIN = 2;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/block_stage_ram.sv
// -----------------------------------------------------------------------------
// block_stage_ram
// Staging copy of every block's two-word parameter register.
// N_BLOCKS x (2*DATA_WIDTH), halves written independently, one synchronous
// read-first read port whose output register only moves when i_rd_en is high.
// Ports:
//   i_clk, i_reset        : clock, async active-high reset (read register only)
//   i_we_lo / i_we_hi     : write strobe for low / high half
//   i_wr_addr, i_wr_data  : write address and half-word data
//   i_rd_en, i_rd_addr    : read strobe and address
//   o_rd_data             : registered read data
// -----------------------------------------------------------------------------
module block_stage_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int N_BLOCKS   = 256,
  parameter int AW         = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_we_lo,
  input  logic                    i_we_hi,
  input  logic [AW-1:0]           i_wr_addr,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic                    i_rd_en,
  input  logic [AW-1:0]           i_rd_addr,
  output logic [2*DATA_WIDTH-1:0] o_rd_data
);

  logic [2*DATA_WIDTH-1:0] r_mem [0:N_BLOCKS-1];
  logic [2*DATA_WIDTH-1:0] r_rd_data;

  // Staging array writes, each half under its own strobe; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_we_lo) begin
      r_mem[i_wr_addr][DATA_WIDTH-1:0] <= i_wr_data;
    end
    if (i_we_hi) begin
      r_mem[i_wr_addr][2*DATA_WIDTH-1:DATA_WIDTH] <= i_wr_data;
    end
  end

  // Read register: samples the array before this edge's write lands (read-first).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_data <= {(2*DATA_WIDTH){1'b0}};
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/block_sync_driver.sv
// -----------------------------------------------------------------------------
// block_sync_driver
// Producer side of the block register file bulk-sync protocol. On commit it
// pulses o_sync, walks o_sync_addr once around the active ring (back to the
// start address), presenting the staged value for each address, then waits
// for the register file's i_syncing flag to drop.
// Ports:
//   i_clk, i_reset                : clock, async active-high reset
//   i_n_active_blocks             : ring length (sampled at commit)
//   i_stage_addr/value/select/we  : staging store write port
//   i_commit, i_start_addr        : start a pass at the given address
//   i_syncing                     : register file busy flag
//   o_sync                        : one-cycle pass start strobe
//   o_sync_addr, o_sync_value     : walked address and its staged value
//   o_busy, o_done                : pass in progress / one-cycle completion
//   o_timeout_err                 : sticky drain timeout, cleared on commit
// -----------------------------------------------------------------------------
module block_sync_driver
  import block_sync_pkg::*;
#(
  parameter  int DATA_WIDTH    = 16,
  parameter  int N_BLOCKS      = 256,
  parameter  int DWELL_CYCLES  = 2,
  parameter  int DRAIN_TIMEOUT = 64,
  localparam int AW            = addr_width(N_BLOCKS)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [AW-1:0]           i_n_active_blocks,
  input  logic [AW-1:0]           i_stage_addr,
  input  logic [DATA_WIDTH-1:0]   i_stage_value,
  input  logic                    i_stage_select,
  input  logic                    i_stage_we,
  input  logic                    i_commit,
  input  logic [AW-1:0]           i_start_addr,
  input  logic                    i_syncing,
  output logic                    o_sync,
  output logic [AW-1:0]           o_sync_addr,
  output logic [2*DATA_WIDTH-1:0] o_sync_value,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_timeout_err
);

  localparam int DCW = addr_width(DWELL_CYCLES);
  localparam int TW  = addr_width(DRAIN_TIMEOUT);
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0]  TMO_LAST   = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [AW-1:0]  ONE_A      = AW'(1);

  generate
    if (DWELL_CYCLES < SYNC_DWELL_MIN) begin : g_dwell_check
      $error("block_sync_driver: DWELL_CYCLES must be at least SYNC_DWELL_MIN");
    end
  endgenerate

  sync_state_t     r_state;
  logic [AW-1:0]   r_n;
  logic [AW-1:0]   r_steps;
  logic [DCW-1:0]  r_dwell;
  logic [TW-1:0]   r_tmo;
  logic            r_sync;
  logic [AW-1:0]   r_sync_addr;
  logic            r_busy;
  logic            r_done;
  logic            r_timeout_err;

  logic [AW-1:0]   w_start_clamp;
  logic [AW:0]     w_addr_inc;
  logic [AW-1:0]   w_next;
  logic            w_dwell_end;
  logic            w_last;
  logic            w_rd_en;
  logic [AW-1:0]   w_rd_addr;

  // Ring arithmetic and end-of-dwell / end-of-pass decisions.
  always_comb begin
    w_start_clamp = (i_start_addr < i_n_active_blocks) ? i_start_addr : {AW{1'b0}};
    w_addr_inc    = {1'b0, r_sync_addr} + {{AW{1'b0}}, 1'b1};
    w_next        = (w_addr_inc == {1'b0, r_n}) ? {AW{1'b0}} : w_addr_inc[AW-1:0];
    w_dwell_end   = (r_dwell == DWELL_LAST);
    // A one-block ring never changes address, so its pass ends after one dwell.
    w_last        = (r_steps == r_n) || (r_n == ONE_A);
  end

  // Staging read request: load the start address at commit, the next ring
  // address when WALK advances, so o_sync_value moves with o_sync_addr.
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_addr = r_sync_addr;
    case (r_state)
      IDLE: begin
        if (i_commit && (i_n_active_blocks != {AW{1'b0}})) begin
          w_rd_en   = 1'b1;
          w_rd_addr = w_start_clamp;
        end else begin
          w_rd_en   = 1'b0;
        end
      end
      WALK: begin
        if (w_dwell_end && !w_last) begin
          w_rd_en   = 1'b1;
          w_rd_addr = w_next;
        end else begin
          w_rd_en   = 1'b0;
        end
      end
      default: begin
        w_rd_en   = 1'b0;
      end
    endcase
  end

  // Pass sequencer: IDLE -> ARM -> WALK -> DRAIN -> IDLE with registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_n           <= {AW{1'b0}};
      r_steps       <= {AW{1'b0}};
      r_dwell       <= {DCW{1'b0}};
      r_tmo         <= {TW{1'b0}};
      r_sync        <= 1'b0;
      r_sync_addr   <= {AW{1'b0}};
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_sync <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_commit) begin
            r_timeout_err <= 1'b0;
            if (i_n_active_blocks == {AW{1'b0}}) begin
              r_done <= 1'b1;
            end else begin
              r_n         <= i_n_active_blocks;
              r_sync_addr <= w_start_clamp;
              r_steps     <= {AW{1'b0}};
              r_dwell     <= {DCW{1'b0}};
              r_sync      <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= ARM;
            end
          end
        end
        ARM: begin
          // The ARM cycle is the first dwell cycle of the start address.
          r_dwell <= r_dwell + DCW'(1);
          r_state <= WALK;
        end
        WALK: begin
          if (w_dwell_end) begin
            r_dwell <= {DCW{1'b0}};
            if (w_last) begin
              r_tmo   <= {TW{1'b0}};
              r_state <= DRAIN;
            end else begin
              r_sync_addr <= w_next;
              r_steps     <= r_steps + ONE_A;
            end
          end else begin
            r_dwell <= r_dwell + DCW'(1);
          end
        end
        DRAIN: begin
          if (!i_syncing) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_tmo == TMO_LAST) begin
            r_timeout_err <= 1'b1;
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  block_stage_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_BLOCKS   (N_BLOCKS),
    .AW         (AW)
  ) u_stage_ram (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_we_lo   (i_stage_we & ~i_stage_select),
    .i_we_hi   (i_stage_we &  i_stage_select),
    .i_wr_addr (i_stage_addr),
    .i_wr_data (i_stage_value),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (o_sync_value)
  );

  assign o_sync        = r_sync;
  assign o_sync_addr   = r_sync_addr;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_block_sync_driver.sv
// -----------------------------------------------------------------------------
// tb_block_sync_driver
// Directed bench for block_sync_driver with a small behavioural register file
// attached to the sync bus. Expected values come from a staging shadow and
// hand-derived cycle numbers.
// -----------------------------------------------------------------------------
module tb_block_sync_driver;

  logic        clk;
  logic        rst;
  logic [7:0]  n_active;
  logic [7:0]  stage_addr;
  logic [15:0] stage_value;
  logic        stage_select;
  logic        stage_we;
  logic        commit;
  logic [7:0]  start_addr;
  logic        syncing;
  logic        o_sync;
  logic [7:0]  o_sync_addr;
  logic [31:0] o_sync_value;
  logic        o_busy;
  logic        o_done;
  logic        o_timeout_err;

  int n_vec;
  int n_err;

  logic [31:0] sh   [0:255];
  logic [31:0] regs [0:255];
  int          ea   [0:15];

  logic        force_sync;
  logic        m_syncing;
  logic        m_single;
  logic [7:0]  m_a1;
  logic [7:0]  m_a2;
  logic [7:0]  m_s;
  logic [31:0] m_v1;

  block_sync_driver dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_n_active_blocks (n_active),
    .i_stage_addr      (stage_addr),
    .i_stage_value     (stage_value),
    .i_stage_select    (stage_select),
    .i_stage_we        (stage_we),
    .i_commit          (commit),
    .i_start_addr      (start_addr),
    .i_syncing         (syncing),
    .o_sync            (o_sync),
    .o_sync_addr       (o_sync_addr),
    .o_sync_value      (o_sync_value),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_timeout_err     (o_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: registers the bus, writes an address the cycle after
  // it notices the change, finishes when the start address comes back.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_syncing <= 1'b0;
      m_single  <= 1'b0;
      m_a1      <= 8'd0;
      m_a2      <= 8'd0;
      m_s       <= 8'd0;
      m_v1      <= 32'd0;
    end else if (o_sync) begin
      m_syncing <= 1'b1;
      m_single  <= (n_active == 8'd1);
      m_a1      <= o_sync_addr;
      m_a2      <= o_sync_addr;
      m_s       <= o_sync_addr;
      m_v1      <= o_sync_value;
    end else if (m_syncing) begin
      m_a1 <= o_sync_addr;
      m_v1 <= o_sync_value;
      m_a2 <= m_a1;
      if (m_single) begin
        regs[m_a1] <= m_v1;
        m_syncing  <= 1'b0;
      end else if (m_a1 != m_a2) begin
        regs[m_a1] <= m_v1;
        if (m_a1 == m_s) m_syncing <= 1'b0;
      end
    end
  end

  assign syncing = m_syncing | force_sync;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic stage_wr(input logic [7:0] a, input logic sel, input logic [15:0] v);
    @(negedge clk);
    stage_addr   = a;
    stage_select = sel;
    stage_value  = v;
    stage_we     = 1'b1;
    if (sel) sh[a][31:16] = v;
    else     sh[a][15:0]  = v;
    @(posedge clk);
    #1 stage_we = 1'b0;
  endtask

  // One commit; checks the walked addresses in ea[], then done timing.
  // wr_cyc: cycle in which to write 16'hBEEF to the high half of address 1.
  // rc_cyc: cycle in which to issue an ignored commit with different inputs.
  task automatic run_pass(input int n, input int st, input int len, input int done_at,
                          input int wr_cyc, input int rc_cyc, input logic exp_tmo);
    int cyc;
    @(negedge clk);
    n_active   = 8'(n);
    start_addr = 8'(st);
    commit     = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    for (int c = 1; c <= len; c++) begin
      chk("sync_addr", {24'd0, o_sync_addr}, 32'(ea[c-1]));
      chk("sync",      {31'd0, o_sync}, {31'd0, (c == 1)});
      chk("busy",      {31'd0, o_busy}, 32'd1);
      chk("sync_value", o_sync_value, sh[ea[c-1]]);
      if (c == 1) chk("tmo_clear", {31'd0, o_timeout_err}, 32'd0);
      if (c == wr_cyc) begin
        stage_addr   = 8'd1;
        stage_select = 1'b1;
        stage_value  = 16'hBEEF;
        stage_we     = 1'b1;
      end
      if (c == wr_cyc + 1) stage_we = 1'b0;
      if (c == rc_cyc) begin
        commit     = 1'b1;
        start_addr = 8'd0;
        n_active   = 8'd2;
      end
      if (c == rc_cyc + 1) commit = 1'b0;
      @(negedge clk);
    end
    cyc = len + 1;
    while (!o_done && cyc < done_at + 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen",  {31'd0, o_done}, 32'd1);
    chk("done_cycle", 32'(cyc), 32'(done_at));
    chk("busy_end",   {31'd0, o_busy}, 32'd0);
    chk("timeout",    {31'd0, o_timeout_err}, {31'd0, exp_tmo});
    @(negedge clk);
    chk("done_pulse", {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    n_active = 8'd0;
    stage_addr = 8'd0;
    stage_value = 16'd0;
    stage_select = 1'b0;
    stage_we = 1'b0;
    commit = 1'b0;
    start_addr = 8'd0;
    force_sync = 1'b0;
    for (int i = 0; i < 256; i++) begin
      sh[i]   = 32'd0;
      regs[i] = 32'd0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sync",  {31'd0, o_sync}, 32'd0);
    chk("rst_addr",  {24'd0, o_sync_addr}, 32'd0);
    chk("rst_value", o_sync_value, 32'd0);
    chk("rst_busy",  {31'd0, o_busy}, 32'd0);
    chk("rst_done",  {31'd0, o_done}, 32'd0);
    chk("rst_tmo",   {31'd0, o_timeout_err}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      stage_wr(8'(i), 1'b1, 16'h00A0 + 16'(i));
      stage_wr(8'(i), 1'b0, 16'h0010 + 16'(i));
    end

    // Normal pass n=4 start=2, with an ignored commit mid-pass
    ea = '{2,2,3,3,0,0,1,1,2,2,0,0,0,0,0,0};
    run_pass(4, 2, 10, 12, 0, 4, 1'b0);
    for (int i = 0; i < 4; i++) chk("regfile_normal", regs[i], sh[i]);

    // Single block
    stage_wr(8'd0, 1'b0, 16'h5555);
    ea = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    run_pass(1, 0, 2, 4, 0, 0, 1'b0);
    chk("regfile_single", regs[0], 32'h00A05555);

    // Empty ring
    @(negedge clk);
    n_active = 8'd0;
    start_addr = 8'd0;
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    chk("empty_done", {31'd0, o_done}, 32'd1);
    chk("empty_sync", {31'd0, o_sync}, 32'd0);
    chk("empty_busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    chk("empty_done2", {31'd0, o_done}, 32'd0);
    chk("empty_busy2", {31'd0, o_busy}, 32'd0);

    // Start clamp: start 7 beyond ring of 3
    ea = '{0,0,1,1,2,2,0,0,0,0,0,0,0,0,0,0};
    run_pass(3, 7, 8, 10, 0, 0, 1'b0);

    // Staging collision on address 1 as it is read
    ea = '{0,0,1,1,2,2,3,3,0,0,0,0,0,0,0,0};
    run_pass(4, 0, 10, 12, 2, 0, 1'b0);
    chk("collide_old", regs[1], 32'h00A10011);
    sh[1][31:16] = 16'hBEEF;
    run_pass(4, 0, 10, 12, 0, 0, 1'b0);
    chk("collide_new", regs[1], 32'hBEEF0011);

    // Drain timeout, then cleared by the next commit
    force_sync = 1'b1;
    ea = '{0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0};
    run_pass(2, 0, 6, 71, 0, 0, 1'b1);
    force_sync = 1'b0;
    run_pass(2, 0, 6, 8, 0, 0, 1'b0);

    // Reset in the middle of WALK
    @(negedge clk);
    n_active = 8'd4;
    start_addr = 8'd0;
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_addr", {24'd0, o_sync_addr}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sync",  {31'd0, o_sync}, 32'd0);
    chk("mid_rst_addr",  {24'd0, o_sync_addr}, 32'd0);
    chk("mid_rst_busy",  {31'd0, o_busy}, 32'd0);
    chk("mid_rst_done",  {31'd0, o_done}, 32'd0);
    chk("mid_rst_value", o_sync_value, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stage_wr(8'(i), 1'b1, 16'h00C0 + 16'(i));
      stage_wr(8'(i), 1'b0, 16'h0030 + 16'(i));
    end
    ea = '{1,1,2,2,3,3,0,0,1,1,0,0,0,0,0,0};
    run_pass(4, 1, 10, 12, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) chk("regfile_after_rst", regs[i], sh[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
